// File: rtl/rsa_io_if.sv
// rsa_io_if: host word bus plus exponentiation-core handshake for rsa_io_ctrl.
interface rsa_io_if #(
   parameter int KEY_W = 64,
   parameter int BUS_W = 32
);
   logic clr, wr_en, rd_en, ready, busy, io_end, err, core_start, core_done;
   logic [BUS_W-1:0] wr_data, rd_data;
   logic [KEY_W-1:0] core_base, core_exp, core_mod, core_result;
   modport master (
      output clr, wr_en, wr_data, rd_en, core_done, core_result,
      input  rd_data, ready, busy, io_end, err, core_start, core_base, core_exp, core_mod
   );
   modport slave (
      input  clr, wr_en, wr_data, rd_en, core_done, core_result,
      output rd_data, ready, busy, io_end, err, core_start, core_base, core_exp, core_mod
   );
endinterface

// File: rtl/rsa_io_ctrl.sv
// rsa_io_ctrl: word-serial operand loader and result reader around the modexp core.
// Define RSA_IO_MODCHK_EN to reject even or sub-3 moduli through the ERR state.
module rsa_io_ctrl #(
   parameter int KEY_W = 64,
   parameter int BUS_W = 32
) (
   input logic clk,
   input logic rst,
   rsa_io_if.slave io
);
   localparam int WORDS = KEY_W / BUS_W;
   localparam int WW = $clog2(3 * WORDS + 1);
   localparam int RW = $clog2(WORDS + 1);
`ifdef RSA_IO_MODCHK_EN
   typedef enum logic [2:0] {IDLE, START, BUSY, DONE, ERR} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, BUSY, DONE} state_t;
`endif
   state_t state, nxt;
   logic [WW-1:0] wcnt;
   logic [RW-1:0] rcnt;
   logic [WORDS-1:0][BUS_W-1:0] base_w, exp_w, mod_w, res_w;
   logic wr_ok, wr_last, rd_ok, rd_last;
   assign wr_ok = state == IDLE && io.wr_en;
   assign wr_last = wr_ok && wcnt == WW'(3 * WORDS - 1);
   assign rd_ok = state == DONE && io.rd_en;
   assign rd_last = rd_ok && rcnt == RW'(WORDS - 1);
`ifdef RSA_IO_MODCHK_EN
   // modulus as it will look once the word on the bus lands
   logic [WORDS-1:0][BUS_W-1:0] mod_nx;
   logic mod_bad;
   always_comb begin
      mod_nx = mod_w;
      mod_nx[WORDS-1] = io.wr_data;
   end
   assign mod_bad = !mod_nx[0][0] || mod_nx < KEY_W'(3);
   assign io.err = state == ERR;
`else
   assign io.err = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
`ifdef RSA_IO_MODCHK_EN
         IDLE: nxt = wr_last ? (mod_bad ? ERR : START) : IDLE;
`else
         IDLE: nxt = wr_last ? START : IDLE;
`endif
         START: nxt = BUSY;
         BUSY: nxt = io.core_done ? DONE : BUSY;
         DONE: nxt = rd_last ? IDLE : DONE;
         default: nxt = state;
      endcase
      if (io.clr) nxt = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wcnt <= '0;
         rcnt <= '0;
         base_w <= '0;
         exp_w <= '0;
         mod_w <= '0;
         res_w <= '0;
      end else if (io.clr) begin
         wcnt <= '0;
         rcnt <= '0;
      end else begin
         if (wr_ok) wcnt <= wr_last ? '0 : wcnt + WW'(1);
         if (rd_ok) rcnt <= rd_last ? '0 : rcnt + RW'(1);
         for (int i = 0; i < WORDS; i++) begin
            if (wr_ok && wcnt == WW'(i)) base_w[i] <= io.wr_data;
            if (wr_ok && wcnt == WW'(WORDS + i)) exp_w[i] <= io.wr_data;
            if (wr_ok && wcnt == WW'(2 * WORDS + i)) mod_w[i] <= io.wr_data;
         end
         if (state == BUSY && io.core_done) res_w <= io.core_result;
      end
   always_comb begin
      io.rd_data = '0;
      for (int i = 0; i < WORDS; i++)
         if (rcnt == RW'(i)) io.rd_data = res_w[i];
   end
   // an abort landing on the launch cycle must not reach the core
   assign io.core_start = state == START && !io.clr;
   assign io.ready = state == IDLE;
   assign io.busy = state == START || state == BUSY;
   assign io.io_end = state == DONE;
   assign io.core_base = base_w;
   assign io.core_exp = exp_w;
   assign io.core_mod = mod_w;
endmodule

// File: tb/tb_rsa_io_ctrl.sv
// tb_rsa_io_ctrl: scoreboard bench driving a 32-bit and a 64-bit controller with behavioural cores.
module tb_rsa_io_ctrl;
   logic clk = 0, rst;
   always #5 clk = ~clk;
   rsa_io_if #(.KEY_W(32), .BUS_W(32)) a_if ();
   rsa_io_if #(.KEY_W(64), .BUS_W(32)) b_if ();
   rsa_io_ctrl #(.KEY_W(32), .BUS_W(32)) dut_a (.clk(clk), .rst(rst), .io(a_if));
   rsa_io_ctrl #(.KEY_W(64), .BUS_W(32)) dut_b (.clk(clk), .rst(rst), .io(b_if));
   int n_tests = 0, n_fail = 0, a_starts = 0, b_starts = 0;
   logic [31:0] qa_rd[$], qb_rd[$];
   logic [95:0] qa_op[$];
   logic [191:0] qb_op[$];
   logic [63:0] b_res;
   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
      logic [63:0] r, x;
      if (m == 0) return 0;
      r = 64'(1) % 64'(m);
      x = 64'(b) % 64'(m);
      for (int i = 0; i < 32; i++) begin
         if (e[i]) r = (r * x) % 64'(m);
         x = (x * x) % 64'(m);
      end
      return r[31:0];
   endfunction
   // behavioural cores: real modexp on the 32-bit side, canned result on the 64-bit side
   initial begin
      a_if.core_done = 0;
      a_if.core_result = '0;
      forever begin
         @(negedge clk);
         if (a_if.core_start) begin
            logic [31:0] r;
            r = modexp(a_if.core_base, a_if.core_exp, a_if.core_mod);
            repeat (4) @(negedge clk);
            a_if.core_result = r;
            a_if.core_done = 1;
            @(negedge clk);
            a_if.core_done = 0;
         end
      end
   end
   initial begin
      b_if.core_done = 0;
      b_if.core_result = '0;
      forever begin
         @(negedge clk);
         if (b_if.core_start) begin
            repeat (6) @(negedge clk);
            b_if.core_result = b_res;
            b_if.core_done = 1;
            @(negedge clk);
            b_if.core_done = 0;
         end
      end
   end
   always @(negedge clk) begin
      if (a_if.core_start) begin
         a_starts++;
         if (qa_op.size() == 0) chk("a_unexpected_start", 1, 0);
         else chk("a_operands", {a_if.core_mod, a_if.core_exp, a_if.core_base}, qa_op.pop_front());
      end
      if (a_if.io_end && a_if.rd_en) begin
         if (qa_rd.size() == 0) chk("a_unexpected_read", 1, 0);
         else chk("a_rd_data", a_if.rd_data, qa_rd.pop_front());
      end
      if (b_if.core_start) begin
         b_starts++;
         if (qb_op.size() == 0) chk("b_unexpected_start", 1, 0);
         else chk("b_operands", {b_if.core_mod, b_if.core_exp, b_if.core_base}, qb_op.pop_front());
      end
      if (b_if.io_end && b_if.rd_en) begin
         if (qb_rd.size() == 0) chk("b_unexpected_read", 1, 0);
         else chk("b_rd_data", b_if.rd_data, qb_rd.pop_front());
      end
   end
   task automatic wr_a(input logic [31:0] d);
      a_if.wr_en = 1;
      a_if.wr_data = d;
      @(posedge clk);
      #1 a_if.wr_en = 0;
   endtask
   task automatic wr_b(input logic [31:0] d);
      b_if.wr_en = 1;
      b_if.wr_data = d;
      @(posedge clk);
      #1 b_if.wr_en = 0;
   endtask
   task automatic rd_a();
      a_if.rd_en = 1;
      @(posedge clk);
      #1 a_if.rd_en = 0;
   endtask
   task automatic rd_b();
      b_if.rd_en = 1;
      @(posedge clk);
      #1 b_if.rd_en = 0;
   endtask
   task automatic load_a(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
      qa_op.push_back({m, e, b});
      wr_a(b);
      wr_a(e);
      wr_a(m);
   endtask
   task automatic wait_end_a();
      for (int i = 0; i < 50 && !a_if.io_end; i++) begin
         @(posedge clk);
         #1;
      end
      chk("a_io_end", a_if.io_end, 1);
   endtask
   task automatic wait_end_b();
      for (int i = 0; i < 50 && !b_if.io_end; i++) begin
         @(posedge clk);
         #1;
      end
      chk("b_io_end", b_if.io_end, 1);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      bit seen;
      rst = 1;
      b_res = '0;
      {a_if.clr, a_if.wr_en, a_if.rd_en, a_if.wr_data} = '0;
      {b_if.clr, b_if.wr_en, b_if.rd_en, b_if.wr_data} = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {a_if.ready, b_if.ready}, 2'b11);
      chk("rst_flags", {a_if.busy, a_if.io_end, a_if.err, a_if.core_start, b_if.busy, b_if.io_end}, 0);
      chk("rst_regs", {a_if.rd_data, a_if.core_mod, b_if.core_base}, 0);
      rst = 0;
      @(posedge clk);
      #1;
      // 32-bit key through the modexp core
      qa_rd.push_back(modexp(32'h032178C4, 32'h11, 32'h07A50679));
      load_a(32'h032178C4, 32'h00000011, 32'h07A50679);
      chk("a_start_cycle", {a_if.core_start, a_if.busy, a_if.ready}, 3'b110);
      @(posedge clk);
      #1;
      chk("a_busy_cycle", {a_if.core_start, a_if.busy}, 2'b01);
      wait_end_a();
      rd_a();
      chk("a_ready_after_read", a_if.ready, 1);
      chk("a_one_start", a_starts, 1);
      // 64-bit key, stray strobes in BUSY and DONE
      b_res = 64'h11223344_55667788;
      qb_op.push_back({64'hA1A1A1A1_A0A0A0A0, 64'hE1E1E1E1_E0E0E0E0, 64'hB1B1B1B1_B0B0B0B0});
      qb_rd.push_back(32'h55667788);
      qb_rd.push_back(32'h11223344);
      wr_b(32'hB0B0B0B0);
      wr_b(32'hB1B1B1B1);
      wr_b(32'hE0E0E0E0);
      wr_b(32'hE1E1E1E1);
      wr_b(32'hA0A0A0A0);
      wr_b(32'hA1A1A1A1);
      chk("b_start", b_if.core_start, 1);
      @(posedge clk);
      #1;
      rd_b();
      chk("b_rd_in_busy", {b_if.busy, b_if.io_end}, 2'b10);
      wait_end_b();
      wr_b(32'hDEADBEEF);
      chk("b_wr_in_done", {b_if.io_end, b_if.ready}, 2'b10);
      chk("b_base_kept", b_if.core_base, 64'hB1B1B1B1_B0B0B0B0);
      rd_b();
      chk("b_mid_read", {b_if.io_end, b_if.ready}, 2'b10);
      rd_b();
      chk("b_ready_after_reads", b_if.ready, 1);
      // abort after two words, then a clean load
      wr_a(32'h12345678);
      wr_a(32'h9ABCDEF0);
      a_if.clr = 1;
      @(posedge clk);
      #1 a_if.clr = 0;
      chk("a_clr_ready", {a_if.ready, a_if.busy}, 2'b10);
      qa_rd.push_back(modexp(32'h00000007, 32'h00000003, 32'h0000000B));
      load_a(32'h00000007, 32'h00000003, 32'h0000000B);
      wait_end_a();
      rd_a();
      chk("a_two_starts", a_starts, 2);
      // asynchronous reset while the core is running
      load_a(32'h00000005, 32'h00000002, 32'h00000017);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      #1;
      chk("a_async_rst", {a_if.io_end, a_if.busy, a_if.ready}, 3'b001);
      chk("a_rst_operands", a_if.core_base, 0);
      @(posedge clk);
      #1 rst = 0;
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1 seen |= a_if.io_end;
      end
      chk("a_late_done_ignored", {seen, a_if.ready}, 2'b01);
      // even modulus
`ifdef RSA_IO_MODCHK_EN
      wr_a(32'h1);
      wr_a(32'h1);
      wr_a(32'h10);
      chk("a_err", {a_if.err, a_if.core_start, a_if.ready}, 3'b100);
      wr_a(32'h5);
      chk("a_err_hold", a_if.err, 1);
      a_if.clr = 1;
      @(posedge clk);
      #1 a_if.clr = 0;
      chk("a_err_clr", {a_if.err, a_if.ready}, 2'b01);
      chk("a_no_start_on_err", a_starts, 3);
`else
      qa_rd.push_back(32'h1);
      load_a(32'h1, 32'h1, 32'h10);
      chk("a_even_mod_start", {a_if.core_start, a_if.err}, 2'b10);
      wait_end_a();
      rd_a();
      chk("a_four_starts", a_starts, 4);
`endif
      chk("queues_drained", {qa_rd.size(), qb_rd.size(), qa_op.size(), qb_op.size()}, 0);
      chk("b_one_start", b_starts, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
